// File: rtl/segre_pkg.sv
// Shared types and widths for the segre core.
// Includes the DTLB walker state and PTE layout.
package segre_pkg;

  localparam int WORD_SIZE          = 32;
  localparam int PHYSICAL_ADDR_SIZE = 20;
  localparam int PAGE_OFFSET_BITS   = 12;
  localparam int VIRT_PAGE_BITS     = 20;
  localparam int PHYS_PAGE_BITS     = 8;
  localparam int TLB_ENTRY_BITS     = 5;
  localparam int WALK_CNT_BITS      = 16;
  localparam int PTE_VALID_BIT      = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    FILL  = 3'd4,
    FAULT = 3'd5
  } walker_state_e;

  typedef struct packed {
    logic [11:0]               rsvd_hi;
    logic [PHYS_PAGE_BITS-1:0] ppage;
    logic [8:0]                rsvd_lo;
    logic [1:0]                mode;
    logic                      valid;
  } pte_t;

endpackage

// File: rtl/segre_sat_counter.sv
// Saturating up-counter with increment enable.
// Holds at all-ones once reached.
module segre_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock_i,
  input  logic             rsn_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clock_i or negedge rsn_i) begin
    if (!rsn_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/segre_dtlb_walker.sv
// DTLB refill engine: one miss at a time, single-level
// page table, PTE read over a valid/ready channel.
module segre_dtlb_walker
  import segre_pkg::*;
(
  input  logic                          clock_i,
  input  logic                          rsn_i,
  input  logic                          miss_valid_i,
  input  logic [WORD_SIZE-1:0]          miss_vaddr_i,
  output logic                          miss_ready_o,
  input  logic                          flush_i,
  input  logic [PHYSICAL_ADDR_SIZE-1:0] ptbr_i,
  output logic                          mem_req_valid_o,
  output logic [PHYSICAL_ADDR_SIZE-1:0] mem_req_addr_o,
  input  logic                          mem_req_ready_i,
  input  logic                          mem_rsp_valid_i,
  input  logic [WORD_SIZE-1:0]          mem_rsp_data_i,
  output logic                          fill_valid_o,
  output logic [TLB_ENTRY_BITS-1:0]     fill_index_o,
  output logic [VIRT_PAGE_BITS-1:0]     fill_vpage_o,
  output logic [PHYS_PAGE_BITS-1:0]     fill_ppage_o,
  output logic [1:0]                    fill_mode_o,
  output logic                          fault_o,
  output logic [WORD_SIZE-1:0]          fault_vaddr_o,
  output logic                          busy_o,
  output logic [WALK_CNT_BITS-1:0]      walk_cnt_o,
  output logic [WALK_CNT_BITS-1:0]      fault_cnt_o
);

  walker_state_e state_q, state_d;

  logic [WORD_SIZE-1:0]          vaddr_q;
  logic [PHYSICAL_ADDR_SIZE-1:0] addr_q;
  logic [PHYSICAL_ADDR_SIZE-1:0] addr_d;
  logic [PHYS_PAGE_BITS-1:0]     ppage_q;
  logic [1:0]                    mode_q;
  logic [WORD_SIZE-1:0]          fvaddr_q;

  logic accept;
  logic pte_ld;
  logic fault_ld;
  pte_t rsp_pte;

  assign rsp_pte = pte_t'(mem_rsp_data_i);

  logic [VIRT_PAGE_BITS-1:0] miss_vpn;
  assign miss_vpn = miss_vaddr_i[WORD_SIZE-1:PAGE_OFFSET_BITS];

  // Base keeps only its page bits; sum wraps modulo 2^20.
  assign addr_d =
    {ptbr_i[PHYSICAL_ADDR_SIZE-1:PAGE_OFFSET_BITS],
     {PAGE_OFFSET_BITS{1'b0}}}
    + {miss_vpn[PHYSICAL_ADDR_SIZE-3:0], 2'b00};

  always_ff @(posedge clock_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    fill_valid_o    = 1'b0;
    fault_o         = 1'b0;
    accept          = 1'b0;
    pte_ld          = 1'b0;
    fault_ld        = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready_o = !flush_i;
        if (miss_valid_i && !flush_i) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          mem_req_valid_o = 1'b1;
          if (mem_req_ready_i) state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else if (rsp_pte.valid) begin
            pte_ld  = 1'b1;
            state_d = FILL;
          end else begin
            fault_ld = 1'b1;
            state_d  = FAULT;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rsp_valid_i) state_d = IDLE;
      end
      FILL: begin
        fill_valid_o = 1'b1;
        state_d      = IDLE;
      end
      FAULT: begin
        fault_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge rsn_i) begin
    if (!rsn_i) begin
      vaddr_q  <= '0;
      addr_q   <= '0;
      ppage_q  <= '0;
      mode_q   <= '0;
      fvaddr_q <= '0;
    end else begin
      if (accept) begin
        vaddr_q <= miss_vaddr_i;
        addr_q  <= addr_d;
      end
      if (pte_ld) begin
        ppage_q <= rsp_pte.ppage;
        mode_q  <= rsp_pte.mode;
      end
      if (fault_ld) fvaddr_q <= vaddr_q;
    end
  end

  assign mem_req_addr_o = addr_q;
  assign fill_vpage_o   = vaddr_q[WORD_SIZE-1:PAGE_OFFSET_BITS];
  assign fill_index_o   =
    vaddr_q[PAGE_OFFSET_BITS+TLB_ENTRY_BITS-1:PAGE_OFFSET_BITS];
  assign fill_ppage_o   = ppage_q;
  assign fill_mode_o    = mode_q;
  assign fault_vaddr_o  = fvaddr_q;
  assign busy_o         = (state_q != IDLE);

  segre_sat_counter #(
    .WIDTH (WALK_CNT_BITS)
  ) u_walk_cnt (
    .clock_i (clock_i),
    .rsn_i   (rsn_i),
    .inc_i   (accept),
    .count_o (walk_cnt_o)
  );

  segre_sat_counter #(
    .WIDTH (WALK_CNT_BITS)
  ) u_fault_cnt (
    .clock_i (clock_i),
    .rsn_i   (rsn_i),
    .inc_i   (fault_ld),
    .count_o (fault_cnt_o)
  );

  // A response is only legal while a request is outstanding.
  a_rsp_legal : assert property (
    @(posedge clock_i) disable iff (!rsn_i)
    mem_rsp_valid_i |-> !(state_q inside {IDLE, REQ})
  ) else $error("walker: response while IDLE/REQ");

endmodule

// File: tb/tb_segre_dtlb_walker.sv
// Directed and random checks of segre_dtlb_walker
// against a behavioural page-walk model.
module tb_segre_dtlb_walker;

  logic        clk;
  logic        rsn;
  logic        miss_valid;
  logic [31:0] miss_vaddr;
  logic        miss_ready;
  logic        flush;
  logic [19:0] ptbr;
  logic        req_valid;
  logic [19:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        fill_valid;
  logic [4:0]  fill_index;
  logic [19:0] fill_vpage;
  logic [7:0]  fill_ppage;
  logic [1:0]  fill_mode;
  logic        fault;
  logic [31:0] fault_vaddr;
  logic        busy;
  logic [15:0] walk_cnt;
  logic [15:0] fault_cnt;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  int unsigned m_walk   = 0;
  int unsigned m_fault  = 0;
  logic [31:0] m_fvaddr = '0;
  logic [19:0] last_req_addr;

  segre_dtlb_walker dut (
    .clock_i         (clk),
    .rsn_i           (rsn),
    .miss_valid_i    (miss_valid),
    .miss_vaddr_i    (miss_vaddr),
    .miss_ready_o    (miss_ready),
    .flush_i         (flush),
    .ptbr_i          (ptbr),
    .mem_req_valid_o (req_valid),
    .mem_req_addr_o  (req_addr),
    .mem_req_ready_i (req_ready),
    .mem_rsp_valid_i (rsp_valid),
    .mem_rsp_data_i  (rsp_data),
    .fill_valid_o    (fill_valid),
    .fill_index_o    (fill_index),
    .fill_vpage_o    (fill_vpage),
    .fill_ppage_o    (fill_ppage),
    .fill_mode_o     (fill_mode),
    .fault_o         (fault),
    .fault_vaddr_o   (fault_vaddr),
    .busy_o          (busy),
    .walk_cnt_o      (walk_cnt),
    .fault_cnt_o     (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Page base plus four bytes per virtual page, modulo 2^20.
  function automatic logic [19:0] pte_addr(
      input logic [19:0] base, input logic [31:0] va);
    int unsigned a;
    a = (int'(base) / 4096) * 4096 + (va / 4096) * 4;
    return 20'(a % 1048576);
  endfunction

  task automatic accept_miss(input logic [31:0] va);
    @(negedge clk);
    miss_valid = 1'b1;
    miss_vaddr = va;
    #1;
    chk("idle_ready", {31'd0, miss_ready}, 1);
    chk("idle_busy", {31'd0, busy}, 0);
    m_walk = sat(m_walk + 1);
    @(negedge clk);
    miss_valid = 1'b0;
    miss_vaddr = $urandom;
  endtask

  task automatic do_walk(input logic [31:0] va,
                         input logic [31:0] pte,
                         input int rdly, input int sdly);
    logic [19:0] ea;
    ea = pte_addr(ptbr, va);
    accept_miss(va);
    for (int i = 0; i < rdly; i++) begin
      req_ready = 1'b0;
      #1;
      chk("bp_valid", {31'd0, req_valid}, 1);
      chk("bp_addr", {12'd0, req_addr}, {12'd0, ea});
      chk("bp_mready", {31'd0, miss_ready}, 0);
      @(negedge clk);
    end
    req_ready = 1'b1;
    #1;
    chk("req_valid", {31'd0, req_valid}, 1);
    chk("req_addr", {12'd0, req_addr}, {12'd0, ea});
    last_req_addr = req_addr;
    @(negedge clk);
    req_ready = 1'b0;
    for (int i = 0; i < sdly; i++) begin
      #1;
      chk("wait_busy", {31'd0, busy}, 1);
      chk("wait_req", {31'd0, req_valid}, 0);
      @(negedge clk);
    end
    rsp_valid = 1'b1;
    rsp_data  = pte;
    #1;
    chk("rsp_nofill", {31'd0, fill_valid}, 0);
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = $urandom;
    #1;
    if (pte[0]) begin
      chk("fill_valid", {31'd0, fill_valid}, 1);
      chk("fill_index", {27'd0, fill_index},
          (va / 4096) % 32);
      chk("fill_vpage", {12'd0, fill_vpage}, va / 4096);
      chk("fill_ppage", {24'd0, fill_ppage},
          (pte / 4096) % 256);
      chk("fill_mode", {30'd0, fill_mode}, (pte / 2) % 4);
      chk("fill_nofault", {31'd0, fault}, 0);
    end else begin
      m_fault  = sat(m_fault + 1);
      m_fvaddr = va;
      chk("fault", {31'd0, fault}, 1);
      chk("fault_nofill", {31'd0, fill_valid}, 0);
      chk("fault_va", fault_vaddr, va);
    end
    @(negedge clk);
    #1;
    chk("end_fill", {31'd0, fill_valid}, 0);
    chk("end_fault", {31'd0, fault}, 0);
    chk("end_ready", {31'd0, miss_ready}, 1);
    chk("end_busy", {31'd0, busy}, 0);
    chk("walk_cnt", {16'd0, walk_cnt}, m_walk);
    chk("fault_cnt", {16'd0, fault_cnt}, m_fault);
    chk("fault_va_hold", fault_vaddr, m_fvaddr);
  endtask

  task automatic to_wait(input logic [31:0] va);
    accept_miss(va);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
  endtask

  initial begin
    rsn        = 1'b0;
    miss_valid = 1'b0;
    miss_vaddr = '0;
    flush      = 1'b0;
    ptbr       = '0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_req", {31'd0, req_valid}, 0);
    chk("rst_fill", {31'd0, fill_valid}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_wcnt", {16'd0, walk_cnt}, 0);
    chk("rst_fcnt", {16'd0, fault_cnt}, 0);
    chk("rst_fva", fault_vaddr, 0);
    chk("rst_addr", {12'd0, req_addr}, 0);
    chk("rst_ppage", {24'd0, fill_ppage}, 0);
    @(negedge clk);
    rsn = 1'b1;

    ptbr = 20'h10000;
    do_walk(32'h00403ABC, 32'h00057005, 0, 0);
    chk("hit_addr", {12'd0, last_req_addr}, 32'h1100C);
    chk("hit_index", {27'd0, fill_index}, 32'h03);
    chk("hit_vpage", {12'd0, fill_vpage}, 32'h00403);
    chk("hit_ppage", {24'd0, fill_ppage}, 32'h57);
    chk("hit_mode", {30'd0, fill_mode}, 32'h2);
    chk("hit_wcnt", {16'd0, walk_cnt}, 1);

    do_walk(32'h00403ABC, 32'h00057004, 0, 0);
    chk("flt_va", fault_vaddr, 32'h00403ABC);
    chk("flt_cnt", {16'd0, fault_cnt}, 1);

    do_walk(32'h12345678, 32'h000A3003, 5, 0);

    @(negedge clk);
    flush      = 1'b1;
    miss_valid = 1'b1;
    #1;
    chk("fl_idle_rdy", {31'd0, miss_ready}, 0);
    @(negedge clk);
    flush      = 1'b0;
    miss_valid = 1'b0;
    #1;
    chk("fl_idle_busy", {31'd0, busy}, 0);
    chk("fl_idle_wcnt", {16'd0, walk_cnt}, m_walk);

    accept_miss(32'h00ABC000);
    flush     = 1'b1;
    req_ready = 1'b1;
    #1;
    chk("fl_req_valid", {31'd0, req_valid}, 0);
    @(negedge clk);
    flush     = 1'b0;
    req_ready = 1'b0;
    #1;
    chk("fl_req_busy", {31'd0, busy}, 0);
    chk("fl_req_rdy", {31'd0, miss_ready}, 1);

    to_wait(32'h00777000);
    flush = 1'b1;
    #1;
    chk("fl_wait_busy", {31'd0, busy}, 1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("drain_busy", {31'd0, busy}, 1);
    chk("drain_rdy", {31'd0, miss_ready}, 0);
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data  = 32'h00057005;
    #1;
    chk("drain_rsp_busy", {31'd0, busy}, 1);
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    chk("drain_nofill", {31'd0, fill_valid}, 0);
    chk("drain_nofault", {31'd0, fault}, 0);
    chk("drain_idle", {31'd0, busy}, 0);
    do_walk(32'h00777000, 32'h00042007, 0, 1);

    to_wait(32'h00888000);
    flush     = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h00057004;
    @(negedge clk);
    flush     = 1'b0;
    rsp_valid = 1'b0;
    #1;
    chk("flrsp_fault", {31'd0, fault}, 0);
    chk("flrsp_fill", {31'd0, fill_valid}, 0);
    chk("flrsp_busy", {31'd0, busy}, 0);
    chk("flrsp_fcnt", {16'd0, fault_cnt}, m_fault);

    ptbr = 20'hFF000;
    do_walk(32'hFFFFF000, 32'h000FF003, 0, 0);
    chk("wrap_addr", {12'd0, last_req_addr}, 32'hFEFFC);

    for (int n = 0; n < 30; n++) begin
      ptbr = 20'($urandom);
      do_walk($urandom, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3));
    end

    @(negedge clk);
    force dut.u_walk_cnt.cnt_q  = 16'hFFFD;
    force dut.u_fault_cnt.cnt_q = 16'hFFFE;
    #1;
    release dut.u_walk_cnt.cnt_q;
    release dut.u_fault_cnt.cnt_q;
    m_walk  = 32'hFFFD;
    m_fault = 32'hFFFE;
    for (int n = 0; n < 3; n++) begin
      do_walk($urandom, 32'h00011000, 0, 0);
    end
    chk("sat_wcnt", {16'd0, walk_cnt}, 32'hFFFF);
    chk("sat_fcnt", {16'd0, fault_cnt}, 32'hFFFF);

    to_wait(32'h00403ABC);
    rsn = 1'b0;
    #1;
    m_walk   = 0;
    m_fault  = 0;
    m_fvaddr = '0;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_req", {31'd0, req_valid}, 0);
    chk("mid_rst_wcnt", {16'd0, walk_cnt}, 0);
    chk("mid_rst_fcnt", {16'd0, fault_cnt}, 0);
    chk("mid_rst_fva", fault_vaddr, 0);
    chk("mid_rst_addr", {12'd0, req_addr}, 0);
    chk("mid_rst_vpage", {12'd0, fill_vpage}, 0);
    @(negedge clk);
    rsn  = 1'b1;
    ptbr = 20'h10000;
    do_walk(32'h00403ABC, 32'h00057005, 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
